present_cipher_core_hs: RTL and testbench
=========================================

// Module: present_cipher_core_hs
// PURPOSE
//  Iterative PRESENT-64 encryption core, successor of the fixed 80-bit encryptor top.
//  - Key size is parametrised: 80 or 128 bits. Round count is parametrised.
//  - Master key is stored separately, so many blocks can be encrypted under one key.
//  - Plaintext input and ciphertext output use valid/ready handshakes.
//  - Output is held under backpressure.
//  - Sits between the host bus interface and the ciphertext FIFO.
// PARAMETERS
//  KEY_WIDTH  80  master key width; only 80 or 128 are legal, any other value is an elaboration error
//  ROUNDS     31  number of round-function iterations, 1..31 (reduced values for test only)
// PORTS
//  clk_i         in   1          single clock, rising edge
//  rst_i         in   1          reset, synchronous, active-high
//  key_i         in   KEY_WIDTH  master key
//  key_load_i    in   1          capture key_i into the master key register
//  data_i        in   64         plaintext block
//  data_valid_i  in   1          plaintext valid
//  data_ready_o  out  1          core can accept plaintext (high in IDLE only)
//  data_o        out  64         ciphertext, registered
//  data_valid_o  out  1          ciphertext valid
//  data_ready_i  in   1          downstream accepts ciphertext
//  busy_o        out  1          high in RUN or HOLD
// BEHAVIOUR
//  Reset (rst_i=1 at a clock edge):
//   - State goes to IDLE.
//   - data_o=0, data_valid_o=0, busy_o=0, data_ready_o=1 in the cycle after reset.
//   - Master key register, working key, state register and round counter are all cleared.
//   - Reset has priority over every other input, including mid-RUN and in HOLD.
//   - A block in flight is discarded; no partial output is produced.
//  Key load:
//   - key_load_i=1 in IDLE: master key <= key_i.
//   - key_load_i is ignored in RUN and HOLD.
//   - key_load_i and an accepted block in the same IDLE cycle: the block uses the NEW key_i.
//  State machine:
//   - IDLE -> RUN when data_valid_i & data_ready_o. On that edge:
//     state <= data_i; wkey <= master key (or key_i, see above); rc <= 1.
//   - RUN, each cycle:
//     - state <= P(S(state ^ wkey[KEY_WIDTH-1 -: 64])).
//     - wkey <= schedule(wkey, rc).
//     - rc <= rc + 1.
//   - RUN -> HOLD on the edge that completes round rc == ROUNDS. On that same edge:
//     data_o <= S/P result ^ top 64 bits of the updated key (final whitening); data_valid_o <= 1.
//   - HOLD: data_o and data_valid_o are held stable until data_valid_o & data_ready_i.
//     That edge: data_valid_o <= 0, go to IDLE.
//   - No new block is accepted in the HOLD->IDLE cycle; data_ready_o rises the next cycle.
//  Round operations:
//   - S-box (all 16 nibbles): C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
//   - pLayer: bit i -> bit (16*i) mod 63; bit 63 stays at 63.
//  Key schedule for 80-bit keys:
//   - Rotate left 61.
//   - S-box on [79:76].
//   - [19:15] ^= rc.
//  Key schedule for 128-bit keys:
//   - Rotate left 61.
//   - S-box on [127:124] and on [123:120].
//   - [66:62] ^= rc.
//  Arithmetic: rc is 5 bits and never wraps, because ROUNDS <= 31.
//  Latency (ROUNDS=31):
//   - Accept edge = edge 0.
//   - Rounds occur on edges 1..31.
//   - data_valid_o is high from edge 31.
//   - Next block can be accepted at the earliest on the edge after the output handshake + 1.
//  data_valid_i while not in IDLE is ignored; the upstream holds it.
// TESTING
//  - K80=0, PT=0 -> data_o=5579C1387B228445, data_valid_o high exactly 31 cycles after accept.
//  - K80=FFFF_FFFFFFFF_FFFFFFFF, PT=0 -> E72C46C0F5945049.
//    Then PT=FFFFFFFF_FFFFFFFF with no key reload -> 3333DCD3213210D2.
//  - K80=0, PT=FFFFFFFF_FFFFFFFF -> A112FFC72F68417B.
//    Hold data_ready_i=0 for 10 cycles: data_o and data_valid_o stay stable;
//    data_ready_o=0 and busy_o=1 throughout.
//  - KEY_WIDTH=128, K=0, PT=0 -> 96DB702A2E6900AF.
//  - Assert rst_i at round 15, then release:
//    data_valid_o=0, data_ready_o=1, no output ever appears.
//    Reload K80=0, PT=0 -> 5579C1387B228445.
//  - key_load_i pulsed during RUN with a new key:
//    current result unchanged (5579C1387B228445 for K=0, PT=0); next block still uses the old key.

Source files
------------

// File: rtl/present_cipher_core_hs.sv
// Iterative PRESENT-64 encryption core with 80/128-bit master key register and
// valid/ready handshakes on plaintext input and ciphertext output.
module present_cipher_core_hs #(
  parameter int unsigned KEY_WIDTH = 80,
  parameter int unsigned ROUNDS    = 31
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [KEY_WIDTH-1:0] key_i,
  input  logic                 key_load_i,
  input  logic [63:0]          data_i,
  input  logic                 data_valid_i,
  output logic                 data_ready_o,
  output logic [63:0]          data_o,
  output logic                 data_valid_o,
  input  logic                 data_ready_i,
  output logic                 busy_o
);

  if (KEY_WIDTH != 80 && KEY_WIDTH != 128) begin : gen_bad_key_width
    $error("present_cipher_core_hs: KEY_WIDTH must be 80 or 128");
  end
  if (ROUNDS < 1 || ROUNDS > 31) begin : gen_bad_rounds
    $error("present_cipher_core_hs: ROUNDS must be in 1..31");
  end

  localparam logic [4:0] LastRc = 5'(ROUNDS);

  typedef enum logic [1:0] {StIdle, StRun, StHold} st_e;

  st_e                  st_q, st_d;
  logic [63:0]          blk_q, blk_d;
  logic [KEY_WIDTH-1:0] wkey_q, wkey_d;
  logic [KEY_WIDTH-1:0] mkey_q, mkey_d;
  logic [4:0]           rc_q, rc_d;
  logic [63:0]          dout_q, dout_d;
  logic                 dvalid_q, dvalid_d;

  logic [KEY_WIDTH-1:0] key_rot, key_next;
  logic [63:0]          round_out, cipher;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [63:0] sbox_layer(input logic [63:0] x);
    logic [63:0] y;
    for (int j = 0; j < 16; j++) begin
      y[4*j +: 4] = sbox(x[4*j +: 4]);
    end
    return y;
  endfunction

  // Bit i moves to (16*i) mod 63; bit 63 is fixed.
  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 63; i++) begin
      y[(16 * i) % 63] = x[i];
    end
    y[63] = x[63];
    return y;
  endfunction

  // Rotate left by 61.
  assign key_rot = {wkey_q[KEY_WIDTH-62:0], wkey_q[KEY_WIDTH-1:KEY_WIDTH-61]};

  if (KEY_WIDTH == 128) begin : gen_ks128
    always_comb begin
      key_next          = key_rot;
      key_next[127:124] = sbox(key_rot[127:124]);
      key_next[123:120] = sbox(key_rot[123:120]);
      key_next[66:62]   = key_rot[66:62] ^ rc_q;
    end
  end else begin : gen_ks80
    always_comb begin
      key_next        = key_rot;
      key_next[79:76] = sbox(key_rot[79:76]);
      key_next[19:15] = key_rot[19:15] ^ rc_q;
    end
  end

  assign round_out = p_layer(sbox_layer(blk_q ^ wkey_q[KEY_WIDTH-1 -: 64]));
  // Final whitening uses the key produced by the last schedule step.
  assign cipher    = round_out ^ key_next[KEY_WIDTH-1 -: 64];

  always_comb begin
    st_d     = st_q;
    blk_d    = blk_q;
    wkey_d   = wkey_q;
    mkey_d   = mkey_q;
    rc_d     = rc_q;
    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    unique case (st_q)
      StIdle: begin
        if (key_load_i) begin
          mkey_d = key_i;
        end
        if (data_valid_i) begin
          st_d   = StRun;
          blk_d  = data_i;
          wkey_d = key_load_i ? key_i : mkey_q;
          rc_d   = 5'd1;
        end
      end
      StRun: begin
        blk_d  = round_out;
        wkey_d = key_next;
        rc_d   = rc_q + 5'd1;
        if (rc_q == LastRc) begin
          st_d     = StHold;
          dout_d   = cipher;
          dvalid_d = 1'b1;
        end
      end
      StHold: begin
        if (data_ready_i) begin
          st_d     = StIdle;
          dvalid_d = 1'b0;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q     <= StIdle;
      blk_q    <= '0;
      wkey_q   <= '0;
      mkey_q   <= '0;
      rc_q     <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      st_q     <= st_d;
      blk_q    <= blk_d;
      wkey_q   <= wkey_d;
      mkey_q   <= mkey_d;
      rc_q     <= rc_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
    end
  end

  assign data_o       = dout_q;
  assign data_valid_o = dvalid_q;
  assign data_ready_o = (st_q == StIdle);
  assign busy_o       = (st_q != StIdle);

endmodule

// File: tb/tb_present_cipher_core_hs.sv
// Bench for present_cipher_core_hs: known-answer table, reset/key-load corner
// sequences, and randomized blocks against an array-based PRESENT model.
module tb_present_cipher_core_hs;

  localparam int Rounds = 31;

  logic         clk = 1'b0;
  logic         rst;
  logic [79:0]  key;
  logic         key_load;
  logic [63:0]  din;
  logic         din_valid;
  logic         din_ready;
  logic [63:0]  dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         busy;

  logic [127:0] k128;
  logic         ld128;
  logic [63:0]  din128;
  logic         dv128;
  logic         drdy128;
  logic [63:0]  dout128;
  logic         dov128;
  logic         rdy128;
  logic         busy128;

  int checks = 0;
  int errors = 0;

  int sbox_tbl [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

  always #5 clk = ~clk;

  present_cipher_core_hs #(.KEY_WIDTH(80), .ROUNDS(Rounds)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .key_i        (key),
    .key_load_i   (key_load),
    .data_i       (din),
    .data_valid_i (din_valid),
    .data_ready_o (din_ready),
    .data_o       (dout),
    .data_valid_o (dout_valid),
    .data_ready_i (dout_ready),
    .busy_o       (busy)
  );

  present_cipher_core_hs #(.KEY_WIDTH(128), .ROUNDS(Rounds)) dut128 (
    .clk_i        (clk),
    .rst_i        (rst),
    .key_i        (k128),
    .key_load_i   (ld128),
    .data_i       (din128),
    .data_valid_i (dv128),
    .data_ready_o (drdy128),
    .data_o       (dout128),
    .data_valid_o (dov128),
    .data_ready_i (rdy128),
    .busy_o       (busy128)
  );

  // Reference: round keys derived by rotating bit positions arithmetically.
  function automatic logic [63:0] ref_enc(input logic [127:0] k_in, input int kw,
                                          input logic [63:0] pt, input int rounds);
    logic [127:0] k, kr;
    logic [63:0]  s, t;
    k = k_in;
    s = pt;
    t = '0;
    for (int r = 1; r <= rounds; r++) begin
      s = s ^ k[kw-1 -: 64];
      for (int j = 0; j < 16; j++) t[4*j +: 4] = 4'(sbox_tbl[s[4*j +: 4]]);
      for (int i = 0; i < 64; i++) s[(i == 63) ? 63 : (16 * i) % 63] = t[i];
      kr = '0;
      for (int i = 0; i < kw; i++) kr[(i + 61) % kw] = k[i];
      kr[kw-1 -: 4] = 4'(sbox_tbl[kr[kw-1 -: 4]]);
      if (kw == 128) begin
        kr[123:120] = 4'(sbox_tbl[kr[123:120]]);
        kr[66:62]   = kr[66:62] ^ 5'(r);
      end else begin
        kr[19:15] = kr[19:15] ^ 5'(r);
      end
      k = kr;
    end
    return s ^ k[kw-1 -: 64];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a clock edge with the 80-bit core in IDLE.
  task automatic run_block(input logic [79:0] k, input bit load, input logic [63:0] pt,
                           input int stall, input bit mid_load, input logic [79:0] mid_key,
                           output logic [63:0] ct);
    logic [63:0] held;
    int lat;
    key = k; key_load = load; din = pt; din_valid = 1'b1; dout_ready = 1'b0;
    check("ready_before_accept", 64'(din_ready), 64'd1);
    @(posedge clk); #1;
    key_load = 1'b0; din_valid = 1'b0;
    lat = 0;
    while (!dout_valid && lat < 100) begin
      if (mid_load && lat == 4) begin
        key = mid_key; key_load = 1'b1; din = ~pt; din_valid = 1'b1;
      end else begin
        key_load = 1'b0; din_valid = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    key_load = 1'b0; din_valid = 1'b0;
    check("out_valid_seen", 64'(dout_valid), 64'd1);
    check("latency", 64'(lat), 64'(Rounds));
    ct = dout;
    held = dout;
    repeat (stall) begin
      @(posedge clk); #1;
      check("hold_data", dout, held);
      check("hold_valid", 64'(dout_valid), 64'd1);
      check("hold_ready_low", 64'(din_ready), 64'd0);
      check("hold_busy", 64'(busy), 64'd1);
    end
    dout_ready = 1'b1;
    @(posedge clk); #1;
    dout_ready = 1'b0;
    check("valid_drop", 64'(dout_valid), 64'd0);
    check("idle_ready", 64'(din_ready), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic run128(input logic [127:0] k, input logic [63:0] pt, output logic [63:0] ct);
    int lat;
    k128 = k; ld128 = 1'b1; din128 = pt; dv128 = 1'b1; rdy128 = 1'b1;
    @(posedge clk); #1;
    ld128 = 1'b0; dv128 = 1'b0;
    lat = 0;
    while (!dov128 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("k128_latency", 64'(lat), 64'(Rounds));
    ct = dout128;
    @(posedge clk); #1;
    check("k128_valid_drop", 64'(dov128), 64'd0);
  endtask

  typedef struct {
    logic [79:0] key;
    bit          load;
    logic [63:0] pt;
    int          stall;
    logic [63:0] ct;
  } vec_t;

  initial begin
    vec_t        vecs [4];
    logic [63:0] ct, exp;
    logic [79:0] mkey_m, k;
    logic [127:0] kb;
    logic [63:0] pt;
    int          mode;
    bit          seen;

    vecs[0] = '{80'h0, 1'b1, 64'h0, 0, 64'h5579C1387B228445};
    vecs[1] = '{{80{1'b1}}, 1'b1, 64'h0, 2, 64'hE72C46C0F5945049};
    vecs[2] = '{80'h0, 1'b0, {64{1'b1}}, 0, 64'h3333DCD3213210D2};
    vecs[3] = '{80'h0, 1'b1, {64{1'b1}}, 10, 64'hA112FFC72F68417B};

    rst = 1'b1; key = '0; key_load = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b0;
    k128 = '0; ld128 = 1'b0; din128 = '0; dv128 = 1'b0; rdy128 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout", dout, 64'h0);
    check("rst_valid", 64'(dout_valid), 64'd0);
    check("rst_ready", 64'(din_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst128_ready", 64'(drdy128), 64'd1);
    rst = 1'b0;

    // Known-answer table; vector 2 relies on the key held from vector 1.
    for (int i = 0; i < 4; i++) begin
      run_block(vecs[i].key, vecs[i].load, vecs[i].pt, vecs[i].stall, 1'b0, 80'h0, ct);
      check($sformatf("kat%0d", i), ct, vecs[i].ct);
    end

    // Reset mid-RUN: block discarded, master key cleared.
    key = {80{1'b1}}; key_load = 1'b1; din = 64'h0; din_valid = 1'b1;
    @(posedge clk); #1;
    key_load = 1'b0; din_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_valid", 64'(dout_valid), 64'd0);
    check("midrst_ready", 64'(din_ready), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_dout", dout, 64'h0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (dout_valid) seen = 1'b1;
    end
    check("midrst_no_output", 64'(seen), 64'd0);
    run_block({80{1'b1}}, 1'b0, 64'h0, 0, 1'b0, 80'h0, ct);
    check("after_rst_cleared_key", ct, 64'h5579C1387B228445);

    // key_load during RUN is ignored, for this block and the next.
    run_block(80'h0, 1'b1, 64'h0, 1, 1'b1, {80{1'b1}}, ct);
    check("midload_current", ct, 64'h5579C1387B228445);
    run_block({80{1'b1}}, 1'b0, 64'h0, 0, 1'b0, 80'h0, ct);
    check("midload_next", ct, 64'h5579C1387B228445);
    mkey_m = 80'h0;

    // Randomized blocks: load in accept cycle, load in an earlier idle cycle, or no load.
    for (int i = 0; i < 10; i++) begin
      k  = {$urandom, $urandom, 16'($urandom)};
      pt = {$urandom, $urandom};
      mode = $urandom_range(0, 2);
      if (mode == 1) begin
        key = k; key_load = 1'b1;
        @(posedge clk); #1;
        key_load = 1'b0;
        mkey_m = k;
      end else if (mode == 2) begin
        mkey_m = k;
      end
      exp = ref_enc({48'h0, mkey_m}, 80, pt, Rounds);
      run_block((mode == 2) ? k : ~k, mode == 2, pt, $urandom_range(0, 3), 1'b0, 80'h0, ct);
      check($sformatf("rand%0d_m%0d", i, mode), ct, exp);
    end

    // 128-bit key instance.
    run128(128'h0, 64'h0, ct);
    check("k128_kat", ct, 64'h96DB702A2E6900AF);
    for (int i = 0; i < 3; i++) begin
      kb = {$urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom};
      exp = ref_enc(kb, 128, pt, Rounds);
      run128(kb, pt, ct);
      check($sformatf("k128_rand%0d", i), ct, exp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
